// File: rtl/fifo_ptr_ctrl_pkg.sv
// Shared constants and types for the FIFO pointer/flag controller.
package fifo_pkg;
    localparam int ADDR_W   = 10;
    localparam int DEPTH    = 1024;
    localparam int BANK_BIT = 9;

    // Pointer carries one extra wrap bit above the address.
    typedef logic [ADDR_W:0] ptr_t;
    // Occupancy 0..DEPTH needs the same width as a pointer.
    typedef logic [ADDR_W:0] count_t;
endpackage

// File: rtl/fifo_ptr_ctrl_if.sv
// Request/status bundle between the FIFO client and the pointer controller.
// Optional almost flags exist only with FIFO_CTRL_ALMOST_FLAGS_EN.
interface fifo_ptr_ctrl_if #(parameter int ADDR_W = fifo_pkg::ADDR_W);
    logic              wr_req;
    logic              rd_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [ADDR_W-1:0] rd_addr;
    logic              wr_en;
    logic              rd_en;
    logic              rd_valid;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              overflow;
    logic              underflow;
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    logic              almost_full;
    logic              almost_empty;

    modport master (output wr_req, rd_req,
                    input  wr_addr, rd_addr, wr_en, rd_en, rd_valid, full, empty,
                           count, overflow, underflow, almost_full, almost_empty);
    modport slave  (input  wr_req, rd_req,
                    output wr_addr, rd_addr, wr_en, rd_en, rd_valid, full, empty,
                           count, overflow, underflow, almost_full, almost_empty);
`else
    modport master (output wr_req, rd_req,
                    input  wr_addr, rd_addr, wr_en, rd_en, rd_valid, full, empty,
                           count, overflow, underflow);
    modport slave  (input  wr_req, rd_req,
                    output wr_addr, rd_addr, wr_en, rd_en, rd_valid, full, empty,
                           count, overflow, underflow);
`endif
endinterface

// File: rtl/fifo_ptr_cnt.sv
// Enabled wrap-around counter with async reset; one per FIFO pointer.
module fifo_ptr_cnt #(
    parameter int W = fifo_pkg::ADDR_W + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en_i,
    output logic [W-1:0] cnt_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Advance by one when enabled; natural overflow gives the wrap.
    always_comb begin
        cnt_d = cnt_q;
        if (en_i) cnt_d = cnt_q + W'(1);
    end

    // Pointer register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;
endmodule

// File: rtl/fifo_ptr_ctrl.sv
// Pointer and flag controller for the two-bank FIFO. Produces the write/read
// addresses (bit BANK_BIT selects the bank), qualified strobes, status flags
// and error pulses. Flags come only from the registered pointers.
// Optional almost-full/almost-empty flags: define FIFO_CTRL_ALMOST_FLAGS_EN.
module fifo_ptr_ctrl #(
    parameter int ADDR_W   = fifo_pkg::ADDR_W
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
   ,parameter int AF_LEVEL = 1020,
    parameter int AE_LEVEL = 4
`endif
) (
    input  logic            clk,
    input  logic            rst,
    fifo_ptr_ctrl_if.slave  bus
);
    import fifo_pkg::*;

    logic [ADDR_W:0] wr_ptr, rd_ptr;
    logic            full, empty, wr_en, rd_en;
    logic            rd_valid_q;

    // Wrap bit differs with equal low bits: writer is a full lap ahead.
    assign full  = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                   (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // Requests are qualified against the registered flags only, so a full
    // FIFO never passes a write through and an empty one never bypasses.
    assign wr_en = bus.wr_req & ~full;
    assign rd_en = bus.rd_req & ~empty;

    fifo_ptr_cnt #(.W(ADDR_W+1)) u_wr_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (wr_en),
        .cnt_o (wr_ptr)
    );

    fifo_ptr_cnt #(.W(ADDR_W+1)) u_rd_cnt (
        .clk   (clk),
        .rst   (rst),
        .en_i  (rd_en),
        .cnt_o (rd_ptr)
    );

    // Memory read data lands one cycle after the accepted read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rd_valid_q <= 1'b0;
        else     rd_valid_q <= rd_en;
    end

    assign bus.wr_addr   = wr_ptr[ADDR_W-1:0];
    assign bus.rd_addr   = rd_ptr[ADDR_W-1:0];
    assign bus.wr_en     = wr_en;
    assign bus.rd_en     = rd_en;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.full      = full;
    assign bus.empty     = empty;
    assign bus.count     = wr_ptr - rd_ptr;
    assign bus.overflow  = bus.wr_req & full;
    assign bus.underflow = bus.rd_req & empty;

`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
    localparam logic [ADDR_W:0] AF_C = (ADDR_W+1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C = (ADDR_W+1)'(AE_LEVEL);

    logic [ADDR_W:0] wr_nxt, rd_nxt, cnt_d;
    logic            af_q, ae_q;

    assign wr_nxt = wr_ptr + {{ADDR_W{1'b0}}, wr_en};
    assign rd_nxt = rd_ptr + {{ADDR_W{1'b0}}, rd_en};
    assign cnt_d  = wr_nxt - rd_nxt;

    // Registered from next-state count so the flags line up with count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            af_q <= 1'b0;
            ae_q <= 1'b1;
        end else begin
            af_q <= (cnt_d >= AF_C);
            ae_q <= (cnt_d <= AE_C);
        end
    end

    assign bus.almost_full  = af_q;
    assign bus.almost_empty = ae_q;
`endif
endmodule

// File: tb/tb_fifo_ptr_ctrl.sv
// Self-checking bench for fifo_ptr_ctrl: a pointer model plus a scoreboard of
// written locations that every accepted read must consume in order.
module tb_fifo_ptr_ctrl;
    import fifo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fifo_ptr_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

    fifo_ptr_ctrl #(.ADDR_W(ADDR_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests = 0;
    int fails = 0;

    ptr_t              wr_m, rd_m;
    logic              exp_rv;
    logic [ADDR_W-1:0] sb[$];

    // One clock: drive requests, check everything against the model, then
    // advance the model at the edge.
    task automatic step(input logic w, input logic r);
        count_t            c;
        logic              acc_w, acc_r, fl, em;
        logic [ADDR_W-1:0] exp_a;
        @(negedge clk);
        bus.wr_req = w;
        bus.rd_req = r;
        #1;
        c     = count_t'(wr_m - rd_m);
        fl    = (c == count_t'(DEPTH));
        em    = (c == 0);
        acc_w = w && !fl;
        acc_r = r && !em;
        tests++; if (bus.count !== c) begin fails++; $display("FAIL count: got %0d want %0d", bus.count, c); end
        tests++; if (bus.full !== fl) begin fails++; $display("FAIL full: got %b want %b (count %0d)", bus.full, fl, c); end
        tests++; if (bus.empty !== em) begin fails++; $display("FAIL empty: got %b want %b (count %0d)", bus.empty, em, c); end
        tests++; if (bus.wr_addr !== wr_m[ADDR_W-1:0]) begin fails++; $display("FAIL wr_addr: got %0d want %0d", bus.wr_addr, wr_m[ADDR_W-1:0]); end
        tests++; if (bus.rd_addr !== rd_m[ADDR_W-1:0]) begin fails++; $display("FAIL rd_addr: got %0d want %0d", bus.rd_addr, rd_m[ADDR_W-1:0]); end
        tests++; if (bus.wr_en !== acc_w) begin fails++; $display("FAIL wr_en: got %b want %b", bus.wr_en, acc_w); end
        tests++; if (bus.rd_en !== acc_r) begin fails++; $display("FAIL rd_en: got %b want %b", bus.rd_en, acc_r); end
        tests++; if (bus.overflow !== (w && fl)) begin fails++; $display("FAIL overflow: got %b want %b", bus.overflow, w && fl); end
        tests++; if (bus.underflow !== (r && em)) begin fails++; $display("FAIL underflow: got %b want %b", bus.underflow, r && em); end
        tests++; if (bus.rd_valid !== exp_rv) begin fails++; $display("FAIL rd_valid: got %b want %b", bus.rd_valid, exp_rv); end
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        tests++; if (bus.almost_full !== (c >= 1020)) begin fails++; $display("FAIL almost_full: got %b at count %0d", bus.almost_full, c); end
        tests++; if (bus.almost_empty !== (c <= 4)) begin fails++; $display("FAIL almost_empty: got %b at count %0d", bus.almost_empty, c); end
`endif
        if (acc_r) begin
            tests++;
            if (sb.size() == 0) begin
                fails++; $display("FAIL sb_read: read accepted with nothing written");
            end else begin
                exp_a = sb.pop_front();
                if (bus.rd_addr !== exp_a) begin fails++; $display("FAIL sb_read: rd_addr %0d want %0d", bus.rd_addr, exp_a); end
            end
        end
        if (acc_w) sb.push_back(wr_m[ADDR_W-1:0]);
        @(posedge clk);
        wr_m   = wr_m + ptr_t'(acc_w);
        rd_m   = rd_m + ptr_t'(acc_r);
        exp_rv = acc_r;
    endtask

    task automatic clear_model();
        wr_m   = '0;
        rd_m   = '0;
        exp_rv = 1'b0;
        sb.delete();
    endtask

    // Value checks shared by the reset tests, written out per call site.
    task automatic test_reset();
        rst = 1'b1;
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        #12;
        tests++; if (bus.empty !== 1'b1) begin fails++; $display("FAIL rst_empty: got %b want 1", bus.empty); end
        tests++; if (bus.full !== 1'b0) begin fails++; $display("FAIL rst_full: got %b want 0", bus.full); end
        tests++; if (bus.count !== '0) begin fails++; $display("FAIL rst_count: got %0d want 0", bus.count); end
        tests++; if (bus.wr_addr !== '0 || bus.rd_addr !== '0) begin fails++; $display("FAIL rst_addr: wr %0d rd %0d want 0 0", bus.wr_addr, bus.rd_addr); end
        tests++; if (bus.rd_valid !== 1'b0) begin fails++; $display("FAIL rst_rd_valid: got %b want 0", bus.rd_valid); end
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        tests++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin fails++; $display("FAIL rst_almost: ae %b af %b want 1 0", bus.almost_empty, bus.almost_full); end
`endif
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0);
            #1;
            if (i == 510) begin
                tests++; if (bus.wr_addr[BANK_BIT] !== 1'b0) begin fails++; $display("FAIL bank_lo: bit9 %b want 0 after 511 writes", bus.wr_addr[BANK_BIT]); end
            end
            if (i == 511) begin
                tests++; if (bus.wr_addr[BANK_BIT] !== 1'b1) begin fails++; $display("FAIL bank_hi: bit9 %b want 1 after 512 writes", bus.wr_addr[BANK_BIT]); end
            end
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
            if (i == 1018) begin
                tests++; if (bus.almost_full !== 1'b0) begin fails++; $display("FAIL af_1019: got %b want 0", bus.almost_full); end
            end
            if (i == 1019) begin
                tests++; if (bus.almost_full !== 1'b1) begin fails++; $display("FAIL af_1020: got %b want 1", bus.almost_full); end
            end
`endif
        end
        tests++; if (bus.full !== 1'b1 || bus.count !== 11'd1024) begin fails++; $display("FAIL fill_full: full %b count %0d want 1 1024", bus.full, bus.count); end
        tests++; if (bus.wr_addr !== '0) begin fails++; $display("FAIL fill_wrap: wr_addr %0d want 0", bus.wr_addr); end
    endtask

    task automatic test_overflow();
        step(1'b1, 1'b0);
        #1;
        tests++; if (bus.wr_addr !== '0 || bus.count !== 11'd1024) begin fails++; $display("FAIL ovf_hold: wr_addr %0d count %0d want 0 1024", bus.wr_addr, bus.count); end
    endtask

    task automatic test_full_both();
        step(1'b1, 1'b1);
        #1;
        tests++; if (bus.count !== 11'd1023) begin fails++; $display("FAIL full_both: count %0d want 1023", bus.count); end
        step(1'b1, 1'b0);
    endtask

    task automatic test_drain();
        for (int j = 0; j < DEPTH; j++) begin
            step(1'b0, 1'b1);
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
            #1;
            if (j == 3) begin
                tests++; if (bus.almost_full !== 1'b1) begin fails++; $display("FAIL af_drain_1020: got %b want 1", bus.almost_full); end
            end
            if (j == 4) begin
                tests++; if (bus.almost_full !== 1'b0) begin fails++; $display("FAIL af_drain_1019: got %b want 0", bus.almost_full); end
            end
`endif
        end
        #1;
        tests++; if (bus.empty !== 1'b1 || bus.rd_valid !== 1'b1) begin fails++; $display("FAIL drain_end: empty %b rd_valid %b want 1 1", bus.empty, bus.rd_valid); end
        tests++; if (sb.size() != 0) begin fails++; $display("FAIL drain_sb: %0d entries left want 0", sb.size()); end
    endtask

    task automatic test_underflow();
        step(1'b0, 1'b1);
        #1;
        tests++; if (bus.count !== '0 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL udf_hold: count %0d rd_valid %b want 0 0", bus.count, bus.rd_valid); end
    endtask

    task automatic test_empty_both();
        step(1'b1, 1'b1);
        #1;
        tests++; if (bus.count !== 11'd1) begin fails++; $display("FAIL empty_both: count %0d want 1", bus.count); end
    endtask

    task automatic test_simultaneous();
        logic [ADDR_W-1:0] wa, ra;
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0);
        #1;
        tests++; if (bus.count !== 11'd5) begin fails++; $display("FAIL simul_pre: count %0d want 5", bus.count); end
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        tests++; if (bus.almost_empty !== 1'b0) begin fails++; $display("FAIL ae_5: got %b want 0", bus.almost_empty); end
`endif
        wa = wr_m[ADDR_W-1:0] + ADDR_W'(10);
        ra = rd_m[ADDR_W-1:0] + ADDR_W'(10);
        for (int k = 0; k < 10; k++) step(1'b1, 1'b1);
        #1;
        tests++; if (bus.count !== 11'd5) begin fails++; $display("FAIL simul_count: count %0d want 5", bus.count); end
        tests++; if (bus.wr_addr !== wa || bus.rd_addr !== ra) begin fails++; $display("FAIL simul_addr: wr %0d rd %0d want %0d %0d", bus.wr_addr, bus.rd_addr, wa, ra); end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 295; k++) step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b1, 1'b0);
        #1;
        tests++; if (bus.count !== 11'd300) begin fails++; $display("FAIL mid_pre: count %0d want 300", bus.count); end
        @(negedge clk);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        #2 rst = 1'b1;
        #1;
        tests++; if (bus.count !== '0 || bus.empty !== 1'b1 || bus.full !== 1'b0) begin fails++; $display("FAIL mid_flags: count %0d empty %b full %b want 0 1 0", bus.count, bus.empty, bus.full); end
        tests++; if (bus.wr_addr !== '0 || bus.rd_addr !== '0 || bus.rd_valid !== 1'b0) begin fails++; $display("FAIL mid_addr: wr %0d rd %0d rv %b want 0 0 0", bus.wr_addr, bus.rd_addr, bus.rd_valid); end
`ifdef FIFO_CTRL_ALMOST_FLAGS_EN
        tests++; if (bus.almost_empty !== 1'b1 || bus.almost_full !== 1'b0) begin fails++; $display("FAIL mid_almost: ae %b af %b want 1 0", bus.almost_empty, bus.almost_full); end
`endif
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        step(1'b1, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
    endtask

    initial begin
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        clear_model();
        test_reset();
        test_fill();
        test_overflow();
        test_full_both();
        test_drain();
        test_underflow();
        test_empty_both();
        test_simultaneous();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
